// File: rtl/traffic_pkg.sv
// Shared light codes, display glyphs and phase-state encoding for the
// N-approach traffic phase controller.
package traffic_pkg;

    localparam logic [1:0] LS_OFF = 2'b00;
    localparam logic [1:0] LS_GRN = 2'b01;
    localparam logic [1:0] LS_YEL = 2'b10;
    localparam logic [1:0] LS_RED = 2'b11;

    localparam logic [6:0] SEG_OFF = 7'b0000001;
    localparam logic [6:0] SEG_GRN = 7'b0010000;
    localparam logic [6:0] SEG_YEL = 7'b1011000;
    localparam logic [6:0] SEG_RED = 7'b0111001;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        WALK   = 2'd2,
        ALLRED = 2'd3
    } phase_t;

    // Maps a 2-bit light code to the segment pattern shown for it.
    function automatic logic [6:0] glyph_of(input logic [1:0] code);
        case (code)
            LS_OFF:  return SEG_OFF;
            LS_GRN:  return SEG_GRN;
            LS_YEL:  return SEG_YEL;
            default: return SEG_RED;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scan: one digit per approach, advancing every cycle.
// Anode and segment pattern are registered together so they never disagree.
module seg_scan
    import traffic_pkg::*;
#(
    parameter int NUM_APPROACH = 2
) (
    input  logic                      clk_out_2,
    input  logic                      reset,
    input  logic [2*NUM_APPROACH-1:0] light_state,
    output logic [6:0]                to_seg,
    output logic [3:0]                lights_on
);

    localparam logic [1:0] LAST_DIG = 2'(NUM_APPROACH - 1);

    logic [1:0] dig;
    logic [1:0] dig_n;
    logic [1:0] code;

    // Next digit and the light code of the approach it will show.
    always_comb begin
        dig_n = (dig == LAST_DIG) ? 2'd0 : dig + 2'd1;
        code  = LS_RED;
        for (int i = 0; i < NUM_APPROACH; i++) begin
            if (i == int'(dig_n)) begin
                code = light_state[2*i +: 2];
            end
        end
    end

    // Digit counter with coherent anode/segment registers.
    always_ff @(posedge clk_out_2) begin
        if (reset) begin
            dig       <= 2'd0;
            to_seg    <= SEG_RED;
            lights_on <= 4'b1110;
        end else begin
            dig       <= dig_n;
            to_seg    <= glyph_of(code);
            lights_on <= ~(4'b0001 << dig_n);
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic phase controller: rotating green with amber and all-red
// clearance, one-shot sensor extension, optional empty-approach skipping,
// latched pedestrian walk phase and an integrated display scan.
//
// state  | meaning
// GREEN  | approach cur green, all others red
// YELLOW | approach cur amber, all others red
// WALK   | all red, pedestrian lamp on
// ALLRED | all red clearance before the next green
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_APPROACH = 2,
    parameter int CNT_W        = 6,
    parameter int TICK_DIV     = 1000,
    parameter int T_GREEN      = 6,
    parameter int T_EXT        = 3,
    parameter int T_YEL        = 2,
    parameter int T_ALLRED     = 1,
    parameter int T_WALK       = 3,
    parameter int SKIP_EMPTY   = 0
) (
    input  logic                      clk_out_2,
    input  logic                      reset,
    input  logic [NUM_APPROACH-1:0]   sensor,
    input  logic                      walk,
    output logic [2*NUM_APPROACH-1:0] light_state,
    output logic                      walk_light,
    output logic [1:0]                phase_idx,
    output logic [6:0]                to_seg,
    output logic [3:0]                lights_on
);

    localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] GX_LAST  = CNT_W'(T_GREEN + T_EXT - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] R_LAST   = CNT_W'(T_ALLRED - 1);
    localparam logic [1:0]      LAST_APP  = 2'(NUM_APPROACH - 1);

    logic [TW-1:0]           tick_cnt;
    logic                    tick;
    phase_t                  state, state_n;
    logic [1:0]              cur, cur_n, nxt;
    logic [CNT_W-1:0]        tmr, tmr_n;
    logic                    ext_done, ext_n;
    logic [NUM_APPROACH-1:0] demand, demand_n;
    logic                    walk_req, walk_req_n;
    logic                    cur_sense, others_dem;
    logic [1:0]              own_code;
    logic [2*NUM_APPROACH-1:0] ls_n;

    assign tick = (tick_cnt == TICK_LAST);

    // Next phase, timer, demand/walk latches and the lamp pattern to register.
    always_comb begin
        state_n    = state;
        cur_n      = cur;
        tmr_n      = tmr;
        ext_n      = ext_done;
        demand_n   = demand | sensor;
        walk_req_n = walk_req | (walk && (state != WALK));
        cur_sense  = 1'b0;
        others_dem = 1'b0;
        nxt        = (cur == LAST_APP) ? 2'd0 : cur + 2'd1;

        for (int i = 0; i < NUM_APPROACH; i++) begin
            if (i == int'(cur)) begin
                cur_sense = sensor[i];
            end else begin
                others_dem = others_dem | demand[i];
            end
        end

        // Descending distance so the nearest demanding approach wins; the
        // current approach itself is the farthest candidate.
        if (SKIP_EMPTY != 0) begin
            for (int k = NUM_APPROACH; k >= 1; k--) begin
                for (int i = 0; i < NUM_APPROACH; i++) begin
                    if (demand[i] && (i == ((int'(cur) + k >= NUM_APPROACH) ?
                                            int'(cur) + k - NUM_APPROACH :
                                            int'(cur) + k))) begin
                        nxt = 2'(i);
                    end
                end
            end
        end

        if (tick) begin
            case (state)
                GREEN: begin
                    if (tmr == (ext_done ? GX_LAST : G_LAST)) begin
                        if (!ext_done && cur_sense && !others_dem && !walk_req) begin
                            ext_n = 1'b1;
                            tmr_n = tmr + 1'b1;
                        end else begin
                            state_n = YELLOW;
                            tmr_n   = '0;
                        end
                    end else begin
                        tmr_n = tmr + 1'b1;
                    end
                end
                YELLOW: begin
                    if (tmr == Y_LAST) begin
                        tmr_n = '0;
                        if (walk_req) begin
                            state_n    = WALK;
                            walk_req_n = 1'b0;
                        end else begin
                            state_n = ALLRED;
                        end
                    end else begin
                        tmr_n = tmr + 1'b1;
                    end
                end
                WALK: begin
                    if (tmr == W_LAST) begin
                        state_n = ALLRED;
                        tmr_n   = '0;
                    end else begin
                        tmr_n = tmr + 1'b1;
                    end
                end
                ALLRED: begin
                    if (tmr == R_LAST) begin
                        state_n = GREEN;
                        cur_n   = nxt;
                        ext_n   = 1'b0;
                        tmr_n   = '0;
                        for (int i = 0; i < NUM_APPROACH; i++) begin
                            if (i == int'(nxt)) begin
                                demand_n[i] = 1'b0;
                            end
                        end
                    end else begin
                        tmr_n = tmr + 1'b1;
                    end
                end
                default: state_n = ALLRED;
            endcase
        end

        case (state_n)
            GREEN:   own_code = LS_GRN;
            YELLOW:  own_code = LS_YEL;
            default: own_code = LS_RED;
        endcase
        ls_n = '1;
        for (int i = 0; i < NUM_APPROACH; i++) begin
            if (i == int'(cur_n)) begin
                ls_n[2*i +: 2] = own_code;
            end
        end
    end

    // Prescaler, phase state and registered lamp outputs.
    always_ff @(posedge clk_out_2) begin
        if (reset) begin
            tick_cnt    <= '0;
            state       <= ALLRED;
            cur         <= LAST_APP;
            tmr         <= '0;
            ext_done    <= 1'b0;
            demand      <= '0;
            walk_req    <= 1'b0;
            light_state <= '1;
            walk_light  <= 1'b0;
            phase_idx   <= LAST_APP;
        end else begin
            tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
            state       <= state_n;
            cur         <= cur_n;
            tmr         <= tmr_n;
            ext_done    <= ext_n;
            demand      <= demand_n;
            walk_req    <= walk_req_n;
            light_state <= ls_n;
            walk_light  <= (state_n == WALK);
            phase_idx   <= cur_n;
        end
    end

    seg_scan #(
        .NUM_APPROACH (NUM_APPROACH)
    ) u_seg_scan (
        .clk_out_2   (clk_out_2),
        .reset       (reset),
        .light_state (light_state),
        .to_seg      (to_seg),
        .lights_on   (lights_on)
    );

endmodule
